ir_decode_stage: RTL and testbench

- Registered, flow-controlled RV32I/RV64I decode stage between fetch and execute.
- Buffers raw instructions and their PCs in a DEPTH-entry queue, then decodes the head combinationally.
- Presents one registered decoded bundle per handshake, with instruction type, fields, sign-extended immediate and an illegal-instruction flag.
- Supports pipeline flush for branches and traps.

---
 rtl/decode_pkg.sv | 46 ++++
 rtl/fifo.sv | 47 ++++
 rtl/ir_decode_comb.sv | 101 ++++++++++
 rtl/ir_decode_stage.sv | 141 ++++++++++++++
 tb/tb_ir_decode_stage.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Shared types for the RV32I/RV64I decode stage: instruction-type codes,
// base opcodes and the decoded bundle that travels from decoder to output register.
package decode_pkg;

    localparam int XLEN_MAX = 64;

    typedef enum logic [2:0] {
        INSTR_R   = 3'd0,
        INSTR_I   = 3'd1,
        INSTR_S   = 3'd2,
        INSTR_B   = 3'd3,
        INSTR_U   = 3'd4,
        INSTR_J   = 3'd5,
        INSTR_ERR = 3'd6
    } instr_type_e;

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LD     = 7'b0000011;
    localparam logic [6:0] ST     = 7'b0100011;
    localparam logic [6:0] ALUI   = 7'b0010011;
    localparam logic [6:0] ALU    = 7'b0110011;
    localparam logic [6:0] ALUI32 = 7'b0011011;
    localparam logic [6:0] ALU32  = 7'b0111011;
    localparam logic [6:0] FENCE  = 7'b0001111;
    localparam logic [6:0] ECSR   = 7'b1110011;

    // pc/imm are sized for the widest datapath; narrower builds use the low bits.
    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        instr_type_e         instr_type;
        logic [6:0]          opcode;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic                arithmetic;
        logic [XLEN_MAX-1:0] imm;
        logic                illegal;
    } decoded_t;

endpackage

// File: rtl/fifo.sv
// Generic circular FIFO with synchronous clear; head is read combinationally.
// Latency: one cycle from push to head visibility.
// Backpressure: none internally; caller must not push when full or pop when empty.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/ir_decode_comb.sv
// Purely combinational RV32I/RV64I decoder: raw instruction + PC -> decoded bundle.
// Latency: zero (combinational). Backpressure: not applicable.
module ir_decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     ir,
    input  logic [XLEN-1:0] pc,
    output decoded_t        dec
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        rv64;
    logic        shift_ok;
    logic        bad;
    instr_type_e typ;
    logic [63:0] imm;

    assign opc  = ir[6:0];
    assign f3   = ir[14:12];
    assign f7   = ir[31:25];
    assign rv64 = (XLEN == 64);

    // RV64 shamt is 6 bits wide, so only ir[31:26] carries the shift kind.
    assign shift_ok = rv64 ? (ir[31:26] == 6'h00 || ir[31:26] == 6'h10)
                           : (f7 == 7'h00 || f7 == 7'h20);

    always_comb begin
        typ = INSTR_ERR;
        bad = 1'b0;
        case (opc)
            LUI, AUIPC: typ = INSTR_U;
            JAL:        typ = INSTR_J;
            JALR: begin
                typ = INSTR_I;
                bad = (f3 != 3'd0);
            end
            BRANCH: begin
                typ = INSTR_B;
                bad = (f3 == 3'd2) || (f3 == 3'd3);
            end
            LD: begin
                typ = INSTR_I;
                bad = (f3 == 3'd7) || (!rv64 && (f3 == 3'd3 || f3 == 3'd6));
            end
            ST: begin
                typ = INSTR_S;
                bad = rv64 ? (f3 > 3'd3) : (f3 > 3'd2);
            end
            ALUI, ALUI32: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    typ = INSTR_R;
                    bad = !shift_ok;
                end else begin
                    typ = INSTR_I;
                end
                if (opc == ALUI32 && !rv64) bad = 1'b1;
            end
            ALU, ALU32: begin
                typ = INSTR_R;
                bad = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
                if (opc == ALU32 && !rv64) bad = 1'b1;
            end
            FENCE, ECSR: typ = INSTR_I;
            default:     bad = 1'b1;
        endcase
        if (ir[1:0] != 2'b11) bad = 1'b1;
        if (bad) typ = INSTR_ERR;
    end

    always_comb begin
        imm = '0;
        case (typ)
            INSTR_I: imm = {{52{ir[31]}}, ir[31:20]};
            INSTR_S: imm = {{52{ir[31]}}, ir[31:25], ir[11:7]};
            INSTR_B: imm = {{51{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            INSTR_U: imm = {{32{ir[31]}}, ir[31:12], 12'h000};
            INSTR_J: imm = {{43{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    always_comb begin
        dec            = '0;
        dec.pc         = XLEN_MAX'(pc);
        dec.instr_type = typ;
        dec.opcode     = opc;
        dec.rs1        = ir[19:15];
        dec.rs2        = ir[24:20];
        dec.rd         = ir[11:7];
        dec.funct3     = f3;
        dec.funct7     = f7;
        dec.arithmetic = ir[30];
        dec.imm        = imm;
        dec.illegal    = bad;
    end

endmodule

// File: rtl/ir_decode_stage.sv
// Decode stage: DEPTH-entry raw queue + registered decoded bundle; DECODE_STATS_EN adds counters.
// Latency: 1 cycle accept->out_valid when empty; capacity DEPTH+1.
// Backpressure: in_ready = queue not full && !flush; bundle held while out_valid && !out_ready.
module ir_decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ir,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      out_instr_type,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic            out_arithmetic,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal,
    output logic [31:0]     stat_decoded,
    output logic [31:0]     stat_illegal
);

    localparam int QW = 32 + XLEN;
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] q_count;
    logic [QW-1:0] q_head;
    logic          q_nonempty;
    logic          q_push;
    logic          q_pop;
    logic          accept;
    logic          deliver;
    logic          load;
    decoded_t      head_dec;
    decoded_t      byp_dec;
    decoded_t      out_q;

    assign in_ready   = (q_count < CW'(DEPTH)) && !flush;
    assign accept     = in_valid && in_ready;
    assign deliver    = out_valid && out_ready;
    assign load       = !out_valid || deliver;
    assign q_nonempty = (q_count != '0);
    assign q_pop      = !flush && load && q_nonempty;
    // An accepted word skips the queue only when the output register takes it directly.
    assign q_push     = accept && !(load && !q_nonempty);

    fifo #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .push     (q_push),
        .push_dat ({in_pc, in_ir}),
        .pop      (q_pop),
        .head_dat (q_head),
        .count    (q_count)
    );

    ir_decode_comb #(.XLEN(XLEN)) u_dec_head (
        .ir  (q_head[31:0]),
        .pc  (q_head[QW-1:32]),
        .dec (head_dec)
    );

    ir_decode_comb #(.XLEN(XLEN)) u_dec_bypass (
        .ir  (in_ir),
        .pc  (in_pc),
        .dec (byp_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            if (q_nonempty) begin
                out_q     <= head_dec;
                out_valid <= 1'b1;
            end else if (accept) begin
                out_q     <= byp_dec;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_pc         = out_q.pc[XLEN-1:0];
    assign out_instr_type = out_q.instr_type;
    assign out_opcode     = out_q.opcode;
    assign out_rs1        = out_q.rs1;
    assign out_rs2        = out_q.rs2;
    assign out_rd         = out_q.rd;
    assign out_funct3     = out_q.funct3;
    assign out_funct7     = out_q.funct7;
    assign out_arithmetic = out_q.arithmetic;
    assign out_imm        = out_q.imm[XLEN-1:0];
    assign out_illegal    = out_q.illegal;

    // High pc/imm bits of the wide bundle are dead when XLEN is 32.
    logic unused_bundle;
    assign unused_bundle = ^out_q;

`ifdef DECODE_STATS_EN
    logic [31:0] decoded_cnt;
    logic [31:0] illegal_cnt;

    // Delivery counts even in a flush cycle; flush never clears the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            decoded_cnt <= '0;
            illegal_cnt <= '0;
        end else if (deliver) begin
            decoded_cnt <= decoded_cnt + 32'd1;
            if (out_q.illegal) illegal_cnt <= illegal_cnt + 32'd1;
        end
    end

    assign stat_decoded = decoded_cnt;
    assign stat_illegal = illegal_cnt;
`else
    assign stat_decoded = '0;
    assign stat_illegal = '0;
`endif

endmodule

// File: tb/tb_ir_decode_stage.sv
// Scoreboard bench for ir_decode_stage (XLEN=32, DEPTH=2): the driver queues expected
// bundles on accept, an independent monitor checks every delivered bundle in order.
module tb_ir_decode_stage;
    import decode_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
`ifdef DECODE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_ir;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [2:0]      out_instr_type;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic            out_arithmetic;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;
    logic [31:0]     stat_decoded;
    logic [31:0]     stat_illegal;

    ir_decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_ir          (in_ir),
        .in_pc          (in_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr_type (out_instr_type),
        .out_opcode     (out_opcode),
        .out_rs1        (out_rs1),
        .out_rs2        (out_rs2),
        .out_rd         (out_rd),
        .out_funct3     (out_funct3),
        .out_funct7     (out_funct7),
        .out_arithmetic (out_arithmetic),
        .out_imm        (out_imm),
        .out_illegal    (out_illegal),
        .stat_decoded   (stat_decoded),
        .stat_illegal   (stat_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [2:0]  typ;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          last_out = -10;
    int          prev_out = -10;
    int          exp_dec  = 0;
    int          exp_ill  = 0;
    logic [31:0] pc_next  = 32'h0000_1000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Monitor: every handshake on the output side consumes one scoreboard entry.
    always @(negedge clk) begin : monitor
        exp_t         e;
        logic [100:0] got;
        logic [100:0] want;
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: pc=%0h opcode=%0h arrived, nothing expected", out_pc, out_opcode);
            end else begin
                e    = sb.pop_front();
                got  = {out_pc, out_instr_type, out_opcode, out_rd, out_rs1, out_rs2,
                        out_funct3, out_funct7, out_arithmetic, out_imm, out_illegal};
                want = {e.pc, e.typ, e.ir[6:0], e.ir[11:7], e.ir[19:15], e.ir[24:20],
                        e.ir[14:12], e.ir[31:25], e.ir[30], e.imm, e.ill};
                if (got !== want) begin
                    errors++;
                    $display("FAIL bundle ir=%08h: got %026h, want %026h", e.ir, got, want);
                end
                exp_dec++;
                exp_ill += int'(e.ill);
                prev_out = last_out;
                last_out = cyc;
            end
        end
    end

    task automatic send(input logic [31:0] ir, input logic [2:0] typ, input logic [31:0] imm,
                        input logic ill, input int budget, output bit acc);
        exp_t e;
        e.ir  = ir;
        e.pc  = pc_next;
        e.typ = typ;
        e.imm = imm;
        e.ill = ill;
        in_ir    = ir;
        in_pc    = pc_next;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int i = 0; i < budget && !acc; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                sb.push_back(e);
                pc_next += 32'd4;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_ok(input logic [31:0] ir, input logic [2:0] typ, input logic [31:0] imm,
                           input logic ill);
        bit acc;
        send(ir, typ, imm, ill, 50, acc);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout ir=%08h: in_ready never rose within 50 cycles", ir);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        bit acc;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ir     = '0;
        in_pc     = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        chk("rst_out_imm", 64'(out_imm), 64'd0);
        chk("rst_stat_decoded", 64'(stat_decoded), 64'd0);
        chk("rst_stat_illegal", 64'(stat_illegal), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single ADDI into an empty stage: visible one cycle after accept.
        send_ok(32'h00500093, INSTR_I, 32'd5, 1'b0);
        @(negedge clk);
        chk("addi_latency_out_valid", 64'(out_valid), 64'd1);
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back LUI then BEQ: consecutive deliveries.
        send_ok(32'h12345137, INSTR_U, 32'h12345000, 1'b0);
        send_ok(32'hFE000EE3, INSTR_B, 32'hFFFFFFFC, 1'b0);
        repeat (3) @(negedge clk);
        chk("lui_beq_spacing", 64'(last_out - prev_out), 64'd1);
        @(posedge clk);
        #1;

        // Two illegal words first, so the illegal counter must read exactly 2.
        send_ok(32'h00000000, INSTR_ERR, 32'd0, 1'b1);
        send_ok(32'h0000007F, INSTR_ERR, 32'd0, 1'b1);
        repeat (3) @(negedge clk);
        chk("stat_illegal_two", 64'(stat_illegal), STATS ? 64'd2 : 64'd0);
        @(posedge clk);
        #1;

        send_ok(32'h4140D093, INSTR_R,   32'd0,        1'b0);
        send_ok(32'h4340D093, INSTR_ERR, 32'd0,        1'b1);
        send_ok(32'h0020A423, INSTR_S,   32'd8,        1'b0);
        send_ok(32'h010000EF, INSTR_J,   32'd16,       1'b0);
        send_ok(32'h00009067, INSTR_ERR, 32'd0,        1'b1);
        send_ok(32'hFFF12283, INSTR_I,   32'hFFFFFFFF, 1'b0);
        send_ok(32'h00016283, INSTR_ERR, 32'd0,        1'b1);
        send_ok(32'h40000033, INSTR_R,   32'd0,        1'b0);
        send_ok(32'h40001033, INSTR_ERR, 32'd0,        1'b1);
        repeat (4) @(posedge clk);
        #1;

        // Capacity: output stalled, DEPTH+1 words fit and the next is refused.
        out_ready = 1'b0;
        send_ok(32'h00100093, INSTR_I, 32'd1, 1'b0);
        send_ok(32'h00200093, INSTR_I, 32'd2, 1'b0);
        send_ok(32'h00300093, INSTR_I, 32'd3, 1'b0);
        send(32'h00400093, INSTR_I, 32'd4, 1'b0, 3, acc);
        chk("fourth_refused", 64'(acc), 64'd0);
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("drained_in_ready", 64'(in_ready), 64'd1);
        chk("drained_scoreboard", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;

        // Flush with a full stage: head delivered in the flush cycle, the rest discarded.
        out_ready = 1'b0;
        send_ok(32'h00A00093, INSTR_I, 32'd10, 1'b0);
        send_ok(32'h00B00093, INSTR_I, 32'd11, 1'b0);
        send_ok(32'h00C00093, INSTR_I, 32'd12, 1'b0);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_ir     = 32'h00D00093;
        in_pc     = 32'hDEAD0000;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_left_two", 64'(sb.size()), 64'd2);
        sb.delete();
        @(negedge clk);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;

        // Stage still works after a flush.
        send_ok(32'h00E00093, INSTR_I, 32'd14, 1'b0);
        repeat (4) @(negedge clk);

        chk("final_scoreboard_empty", 64'(sb.size()), 64'd0);
        chk("final_stat_decoded", 64'(stat_decoded), STATS ? 64'(exp_dec) : 64'd0);
        chk("final_stat_illegal", 64'(stat_illegal), STATS ? 64'(exp_ill) : 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
